dual_edge_mod_counter: RTL and testbench

DUAL_EDGE_MOD_COUNTER -- requirements
Module: dual_edge_mod_counter

---
 rtl/dual_edge_cnt_pkg.sv | 53 +++++
 rtl/dual_edge_reg.sv | 34 +++
 rtl/dual_edge_mod_counter.sv | 83 ++++++++
 tb/tb_dual_edge_mod_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dual_edge_cnt_pkg.sv
// Shared constants and the per-edge step function for the dual-edge modulo counter.
package dual_edge_cnt_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_MODULUS = 16;
    localparam int STEP_W      = 32;

    typedef struct packed {
        logic [STEP_W-1:0] next;
        logic              wrap;
    } step_t;

    // Priority is load, then enable, then hold; loads above the range clamp to the top value.
    function automatic step_t step_fn(
        input logic [STEP_W-1:0] count,
        input logic              load,
        input logic [STEP_W-1:0] load_val,
        input logic              en,
        input logic              up_dn,
        input logic [STEP_W-1:0] modulus
    );
        step_t r;
        r.next = count;
        r.wrap = 1'b0;
        if (load) begin
            if (load_val >= modulus) begin
                r.next = modulus - 32'd1;
            end else begin
                r.next = load_val;
            end
        end else if (en) begin
            if (up_dn) begin
                if (count == modulus - 32'd1) begin
                    r.next = 32'd0;
                    r.wrap = 1'b1;
                end else begin
                    r.next = count + 32'd1;
                end
            end else begin
                if (count == 32'd0) begin
                    r.next = modulus - 32'd1;
                    r.wrap = 1'b1;
                end else begin
                    r.next = count - 32'd1;
                end
            end
        end else begin
            r.next = count;
        end
        return r;
    endfunction

endpackage

// File: rtl/dual_edge_reg.sv
// Dual-edge register: rising-edge half P and falling-edge half N, value presented as P ^ N.
module dual_edge_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] p_r;
    logic [W-1:0] n_r;

    // Rising-edge half stores d ^ N so that P ^ N equals d right after the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_r <= {W{1'b0}};
        end else begin
            p_r <= d ^ n_r;
        end
    end

    // Falling-edge half stores d ^ P so that P ^ N equals d right after the edge.
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            n_r <= {W{1'b0}};
        end else begin
            n_r <= d ^ p_r;
        end
    end

    assign q = p_r ^ n_r;

endmodule

// File: rtl/dual_edge_mod_counter.sv
// Modulo counter stepping on both clock edges, with sticky wrap flag.
// Define DUAL_EDGE_CNT_DOWN_EN to honour up_dn; otherwise the counter is up-only.
module dual_edge_mod_counter
    import dual_edge_cnt_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
);

    if (WIDTH < 1 || WIDTH > STEP_W - 1 || MODULUS < 2 ||
        64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_params
        $error("dual_edge_mod_counter: MODULUS must lie in 2..2**WIDTH and WIDTH in 1..31");
    end

    localparam logic [STEP_W-1:0] MOD_L = 32'(MODULUS);
    localparam logic [WIDTH-1:0]  TOP_L = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] next_count_s;
    logic             wrapped_s;
    logic             next_wrapped_s;
    logic             dir_s;
    step_t            step_s;
    logic             unused_hi_s;

`ifdef DUAL_EDGE_CNT_DOWN_EN
    assign dir_s = up_dn;
`else
    logic unused_dir_s;
    assign unused_dir_s = up_dn;
    assign dir_s        = 1'b1;
`endif

    // Next count and sticky wrap; a load always clears the flag, even on a would-be wrap.
    always_comb begin
        step_s       = step_fn(32'(count_s), load, 32'(load_val), en, dir_s, MOD_L);
        next_count_s = step_s.next[WIDTH-1:0];
        if (load) begin
            next_wrapped_s = 1'b0;
        end else begin
            next_wrapped_s = wrapped_s | step_s.wrap;
        end
    end

    assign unused_hi_s = ^step_s.next[STEP_W-1:WIDTH];

    dual_edge_reg #(.W(WIDTH)) u_count_reg (
        .clk  (clk),
        .rstn (rstn),
        .d    (next_count_s),
        .q    (count_s)
    );

    dual_edge_reg #(.W(1)) u_wrapped_reg (
        .clk  (clk),
        .rstn (rstn),
        .d    (next_wrapped_s),
        .q    (wrapped_s)
    );

    // Terminal count follows the current direction, independent of enable.
    always_comb begin
        if (dir_s) begin
            tc = (count_s == TOP_L);
        end else begin
            tc = (count_s == {WIDTH{1'b0}});
        end
    end

    assign count   = count_s;
    assign wrapped = wrapped_s;

endmodule

// File: tb/tb_dual_edge_mod_counter.sv
// Scoreboard bench for dual_edge_mod_counter (WIDTH=4, MODULUS=10, 20 ns clock).
module tb_dual_edge_mod_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk;
    logic         rstn;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         up_dn;
    logic [W-1:0] count;
    logic         tc;
    logic         wrapped;

    typedef struct {
        logic [W-1:0] cnt;
        logic         wr;
        logic         tc;
        string        tag;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] m_count;
    logic         m_wrapped;

`ifdef DUAL_EDGE_CNT_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    dual_edge_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .up_dn    (up_dn),
        .count    (count),
        .tc       (tc),
        .wrapped  (wrapped)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Drive one edge's inputs, predict the result, then check it mid-phase after the edge.
    task automatic do_edge(input logic ld, input logic [W-1:0] lv, input logic e,
                           input logic ud, input string tag);
        exp_t x;
        logic ud_eff;
        exp_t got;
        load     = ld;
        load_val = lv;
        en       = e;
        up_dn    = ud;
        ud_eff   = DOWN_EN ? ud : 1'b1;
        if (ld) begin
            m_count   = (int'(lv) >= M) ? W'(M - 1) : lv;
            m_wrapped = 1'b0;
        end else if (e) begin
            if (ud_eff) begin
                if (int'(m_count) == M - 1) begin
                    m_count   = 4'd0;
                    m_wrapped = 1'b1;
                end else begin
                    m_count = m_count + 4'd1;
                end
            end else begin
                if (m_count == 4'd0) begin
                    m_count   = W'(M - 1);
                    m_wrapped = 1'b1;
                end else begin
                    m_count = m_count - 4'd1;
                end
            end
        end
        x.cnt = m_count;
        x.wr  = m_wrapped;
        x.tc  = ud_eff ? (int'(m_count) == M - 1) : (m_count == 4'd0);
        x.tag = tag;
        sb_q.push_back(x);
        @(clk);
        #5;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb_q.pop_front();
            if (count !== got.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d expected %0d at %0t", got.tag, count, got.cnt, $time);
            end
            n_checks++;
            if (wrapped !== got.wr) begin
                n_fail++;
                $display("FAIL %s wrapped: got %b expected %b at %0t", got.tag, wrapped, got.wr, $time);
            end
            n_checks++;
            if (tc !== got.tc) begin
                n_fail++;
                $display("FAIL %s tc: got %b expected %b at %0t", got.tag, tc, got.tc, $time);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b1; load = 1'b0; load_val = 4'd0; up_dn = 1'b1;
        #2;
        n_checks++;
        if (count !== 4'd0 || wrapped !== 1'b0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got count=%0d wrapped=%b tc=%b expected 0/0/0", count, wrapped, tc);
        end
        up_dn = 1'b0;
        #1;
        n_checks++;
        if (tc !== DOWN_EN) begin
            n_fail++;
            $display("FAIL reset_tc_down: got %b expected %b", tc, DOWN_EN);
        end
        up_dn = 1'b1;
        #2;
        rstn      = 1'b1;
        m_count   = 4'd0;
        m_wrapped = 1'b0;
        do_edge(1'b0, 4'd0, 1'b1, 1'b1, "first_step");
    endtask

    task automatic test_up_wrap();
        do_edge(1'b1, 4'd0, 1'b0, 1'b1, "load_zero");
        for (int i = 0; i < 10; i++) do_edge(1'b0, 4'd0, 1'b1, 1'b1, "up_wrap");
        for (int i = 0; i < 2; i++) do_edge(1'b0, 4'd0, 1'b0, 1'b1, "hold_sticky");
    endtask

    task automatic test_down_wrap();
        do_edge(1'b1, 4'd2, 1'b0, 1'b0, "load_two");
        for (int i = 0; i < 4; i++) do_edge(1'b0, 4'd0, 1'b1, 1'b0, "down_wrap");
    endtask

    task automatic test_up_only();
        do_edge(1'b1, 4'd0, 1'b0, 1'b0, "load_zero_uo");
        for (int i = 0; i < 10; i++) do_edge(1'b0, 4'd0, 1'b1, 1'b0, "up_only");
    endtask

    task automatic test_load_priority();
        if (clk == 1'b0) do_edge(1'b0, 4'd0, 1'b0, 1'b1, "align_fall");
        do_edge(1'b1, 4'd13, 1'b1, 1'b1, "load_clamp_fall");
        for (int i = 0; i < 4; i++) do_edge(1'b0, 4'd0, 1'b0, 1'b1, "hold_nine");
        do_edge(1'b1, 4'd10, 1'b0, 1'b1, "load_clamp_ten");
        do_edge(1'b1, 4'd15, 1'b0, 1'b1, "load_clamp_max");
        do_edge(1'b1, 4'd3, 1'b1, 1'b1, "load_over_wrap");
        do_edge(1'b1, 4'd9, 1'b0, 1'b1, "load_nine");
        do_edge(1'b0, 4'd0, 1'b1, 1'b1, "wrap_again");
        do_edge(1'b1, 4'd7, 1'b0, 1'b1, "back_to_back_a");
        do_edge(1'b1, 4'd4, 1'b1, 1'b1, "back_to_back_b");
        do_edge(1'b0, 4'd0, 1'b1, 1'b1, "after_loads");
    endtask

    task automatic test_mid_reset();
        do_edge(1'b1, 4'd8, 1'b0, 1'b1, "load_eight");
        for (int i = 0; i < 7; i++) do_edge(1'b0, 4'd0, 1'b1, 1'b1, "count_to_five");
        rstn = 1'b0;
        #1;
        n_checks++;
        if (count !== 4'd0 || wrapped !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got count=%0d wrapped=%b expected 0/0", count, wrapped);
        end
        #1;
        rstn      = 1'b1;
        m_count   = 4'd0;
        m_wrapped = 1'b0;
        for (int i = 0; i < 3; i++) do_edge(1'b0, 4'd0, 1'b1, 1'b1, "resume");
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        if (DOWN_EN) test_down_wrap();
        else         test_up_only();
        test_load_priority();
        test_mid_reset();
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
